// File: rtl/irq_sequencer.sv
// irq_sequencer: edge-triggered interrupt collector and sequencer for the fetch stage.
// Latches rising edges of irq_src into PENDING, selects the lowest-index enabled
// request, raises alert with the handler vector, and then tracks the interrupt
// through acknowledge and reti so that only one interrupt is outstanding at a time.
//
// Build option: define IRQ_SEQ_SYNC_EN to put a 2-flop synchronizer on every
// irq_src bit ahead of edge detection. This adds two cycles of source latency.
// The default build (macro undefined) treats irq_src as synchronous to clk.
//
// FSM states:
//   state   | meaning
//   IDLE    | no interrupt latched; waiting for an eligible request
//   ALERT   | winner latched in active_id; alert raised, waiting for if_interrupt
//   SERVICE | handler running against the saved PC; waiting for reti
module irq_sequencer #(
  parameter int          NUM_IRQ      = 8,
  parameter logic [31:0] VEC_BASE_RST = 32'h0000_0100
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_src,
  input  logic               if_interrupt,
  input  logic               if_int_mask,
  input  logic               if_stall,
  input  logic               reti,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_addr,
  input  logic [31:0]        cfg_wdata,
  output logic [31:0]        cfg_rdata,
  output logic               alert,
  output logic [31:0]        irq_vector,
  output logic               irq_active,
  output logic [3:0]         active_id
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ALERT   = 2'd1,
    SERVICE = 2'd2
  } state_t;

  localparam logic [1:0] ADDR_ENABLE   = 2'd0;
  localparam logic [1:0] ADDR_PENDING  = 2'd1;
  localparam logic [1:0] ADDR_STATUS   = 2'd2;
  localparam logic [1:0] ADDR_VEC_BASE = 2'd3;

  state_t             state_q, state_d;
  logic [NUM_IRQ-1:0] src_s;
  logic [NUM_IRQ-1:0] irq_prev_q;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] enable_q;
  logic [31:0]        vec_base_q;
  logic [3:0]         active_id_q, active_id_d;
  logic [NUM_IRQ-1:0] edge_det;
  logic [NUM_IRQ-1:0] req;
  logic               req_any;
  logic [3:0]         win_id;
  logic [NUM_IRQ-1:0] w1c_mask;
  logic [NUM_IRQ-1:0] ack_mask;
  logic               ack;
  logic               wr_enable, wr_pending, wr_vec_base;

`ifdef IRQ_SEQ_SYNC_EN
  logic [NUM_IRQ-1:0] sync1_q, sync2_q;

  // Two-stage synchronizer for asynchronous interrupt sources.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_src;
      sync2_q <= sync1_q;
    end
  end

  assign src_s = sync2_q;
`else
  assign src_s = irq_src;
`endif

  assign edge_det    = src_s & ~irq_prev_q;
  assign req         = pending_q & enable_q;
  assign req_any     = |req;
  assign ack         = (state_q == ALERT) && if_interrupt;
  assign wr_enable   = cfg_we && (cfg_addr == ADDR_ENABLE);
  assign wr_pending  = cfg_we && (cfg_addr == ADDR_PENDING);
  assign wr_vec_base = cfg_we && (cfg_addr == ADDR_VEC_BASE);
  assign w1c_mask    = wr_pending ? cfg_wdata[NUM_IRQ-1:0] : '0;
  assign active_id   = active_id_q;

  // Lowest-index enabled pending request wins; scan high to low so the last hit sticks.
  always_comb begin
    win_id = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) win_id = 4'(i);
    end
  end

  // One-hot of the latched id, applied only on the acknowledge edge.
  always_comb begin
    ack_mask = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (ack && (active_id_q == 4'(i))) ack_mask[i] = 1'b1;
    end
  end

  // Clears (W1C and acknowledge) apply first so a same-cycle new edge keeps the bit set.
  always_comb begin
    pending_d = (pending_q & ~(w1c_mask | ack_mask)) | edge_det;
  end

  // Edge history, pending, and software-visible configuration registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_prev_q <= '0;
      pending_q  <= '0;
      enable_q   <= '0;
      vec_base_q <= {VEC_BASE_RST[31:4], 4'b0000};
    end else begin
      irq_prev_q <= src_s;
      pending_q  <= pending_d;
      if (wr_enable)   enable_q   <= cfg_wdata[NUM_IRQ-1:0];
      if (wr_vec_base) vec_base_q <= {cfg_wdata[31:4], 4'b0000};
    end
  end

  // FSM state and latched interrupt id.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      active_id_q <= '0;
    end else begin
      state_q     <= state_d;
      active_id_q <= active_id_d;
    end
  end

  // Next-state and fetch-stage outputs; once in ALERT the request is committed.
  always_comb begin
    state_d     = state_q;
    active_id_d = active_id_q;
    alert       = 1'b0;
    irq_active  = 1'b0;
    irq_vector  = '0;
    case (state_q)
      IDLE: begin
        if (req_any && !if_int_mask && !if_stall) begin
          state_d     = ALERT;
          active_id_d = win_id;
        end
      end
      ALERT: begin
        alert      = 1'b1;
        irq_vector = vec_base_q + 32'({active_id_q, 4'b0000});
        if (if_interrupt) state_d = SERVICE;
      end
      SERVICE: begin
        irq_active = 1'b1;
        if (reti) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Zero-latency register read mux.
  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      ADDR_ENABLE:   cfg_rdata[NUM_IRQ-1:0] = enable_q;
      ADDR_PENDING:  cfg_rdata[NUM_IRQ-1:0] = pending_q;
      ADDR_STATUS:   cfg_rdata = {26'b0, irq_active, alert, active_id_q};
      ADDR_VEC_BASE: cfg_rdata = vec_base_q;
      default:       cfg_rdata = '0;
    endcase
  end

endmodule
